rd_data_collect: RTL and testbench

Read-data return path for the DDR2 user interface: the receiving end of the read commands issued by the command generator. Captures read bursts returned by the memory controller, forwards every beat into the output FIFO, tracks outstanding read commands, and drives the `rd_en` read-permission signal back to the command generator. Controller read data cannot be stalled, so this block throttles at the command level.

---
 rtl/rd_data_collect.sv | 127 ++++++++++++
 tb/tb_rd_data_collect.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_data_collect.sv
// ============================================================================
// rd_data_collect - DDR2 read-data return path: forwards read beats to the
// output FIFO, tracks outstanding read commands and grants rd_en credit.
// Optional watchdog enabled by defining RD_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module rd_data_collect #(
  parameter int DATA_WIDTH      = 64,
  parameter int READ_BURST      = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  phy_init_done,
  input  logic                  rd_addr_en,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data_fifo_out,
  input  logic                  out_fifo_prog_full,
  output logic                  out_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] out_fifo_din,
  output logic                  rd_en,
  output logic [3:0]            outstanding_cnt,
  output logic                  burst_done,
  output logic                  err_overflow,
  output logic                  err_unexpected,
  output logic                  err_timeout
);

  localparam int              BEATS    = READ_BURST / 2;
  localparam int              BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  wr_en_q, done_q, rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  ovf_q, unexp_q;
  logic                  accept, last_beat, ovf_set;

  always_comb begin
    accept    = rd_data_valid && (state_q != IDLE);
    last_beat = accept && (beat_q == LAST_BEAT);
    cnt_d     = cnt_q;
    ovf_set   = 1'b0;
    // A command and a completion in the same cycle cancel out.
    if (rd_addr_en && !last_beat) begin
      if (cnt_q == MAX_CNT) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + 4'd1;
    end else if (last_beat && !rd_addr_en) begin
      cnt_d = cnt_q - 4'd1;
    end
    beat_d = beat_q;
    if (accept) beat_d = last_beat ? '0 : beat_q + BW'(1);
    rd_en_d = phy_init_done && !out_fifo_prog_full &&
              (({1'b0, cnt_q} + {4'd0, rd_addr_en}) < {1'b0, MAX_CNT});
    if (cnt_d == 4'd0)      state_d = IDLE;
    else if (beat_d != '0)  state_d = CAPTURE;
    else                    state_d = WAIT_DATA;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      beat_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      din_q   <= '0;
      rd_en_q <= 1'b0;
      ovf_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      wr_en_q <= accept;
      done_q  <= last_beat;
      if (accept) din_q <= rd_data_fifo_out;
      rd_en_q <= rd_en_d;
      if (ovf_set) ovf_q <= 1'b1;
      if (rd_data_valid && (state_q == IDLE)) unexp_q <= 1'b1;
    end
  end

`ifdef RD_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd_q;
  logic       tmo_q;

  // Counts idle cycles with reads pending; holds once the limit is hit.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wd_q  <= 8'd0;
      tmo_q <= 1'b0;
    end else if ((state_q == IDLE) || rd_data_valid) begin
      wd_q <= 8'd0;
    end else if (wd_q != TIMEOUT_LIM) begin
      wd_q <= wd_q + 8'd1;
      if ((wd_q + 8'd1) == TIMEOUT_LIM) tmo_q <= 1'b1;
    end
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign out_fifo_wr_en  = wr_en_q;
  assign out_fifo_din    = din_q;
  assign rd_en           = rd_en_q;
  assign outstanding_cnt = cnt_q;
  assign burst_done      = done_q;
  assign err_overflow    = ovf_q;
  assign err_unexpected  = unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_data_collect.sv
// ============================================================================
// tb_rd_data_collect - self-checking bench for rd_data_collect: vector table,
// directed corner sequences and randomized traffic against a cycle model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rd_data_collect;

  localparam int DW      = 64;
  localparam int BEATS   = 4;
  localparam int MAXO    = 8;
  localparam int TIMEOUT = 255;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b0;
  logic          phy_init_done = 1'b0;
  logic          rd_addr_en = 1'b0;
  logic          rd_data_valid = 1'b0;
  logic [DW-1:0] rd_data_fifo_out = '0;
  logic          out_fifo_prog_full = 1'b0;
  logic          out_fifo_wr_en;
  logic [DW-1:0] out_fifo_din;
  logic          rd_en;
  logic [3:0]    outstanding_cnt;
  logic          burst_done;
  logic          err_overflow, err_unexpected, err_timeout;

  rd_data_collect #(
    .DATA_WIDTH(DW), .READ_BURST(8), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .phy_init_done(phy_init_done),
    .rd_addr_en(rd_addr_en), .rd_data_valid(rd_data_valid),
    .rd_data_fifo_out(rd_data_fifo_out), .out_fifo_prog_full(out_fifo_prog_full),
    .out_fifo_wr_en(out_fifo_wr_en), .out_fifo_din(out_fifo_din), .rd_en(rd_en),
    .outstanding_cnt(outstanding_cnt), .burst_done(burst_done),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected),
    .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  int m_cnt, m_beat, m_wd;
  bit m_ovf, m_unexp, m_tmo;
  int wr_count, done_count;
  logic [DW-1:0] got_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    rd_addr_en = 0; rd_data_valid = 0; rd_data_fifo_out = '0;
    out_fifo_prog_full = 0; phy_init_done = 0;
    #2;
    chk("rst_wr_en", out_fifo_wr_en, 0);
    chk("rst_cnt", outstanding_cnt, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_errs", {err_overflow, err_unexpected, err_timeout}, 0);
    chk("rst_din", out_fifo_din, 0);
    @(posedge sys_clk); #1;
    reset = 1'b0;
    m_cnt = 0; m_beat = 0; m_wd = 0; m_ovf = 0; m_unexp = 0; m_tmo = 0;
    wr_count = 0; done_count = 0; got_q.delete();
  endtask

  // One clock: apply inputs, predict from the rules, advance, compare.
  task automatic step(input bit addr, input bit valid, input logic [DW-1:0] data,
                      input bit pf, input bit pid);
    bit e_wr, e_done, e_rden;
    bit acc, last;
    rd_addr_en = addr; rd_data_valid = valid; rd_data_fifo_out = data;
    out_fifo_prog_full = pf; phy_init_done = pid;
    acc    = valid && (m_cnt > 0);
    last   = acc && (m_beat == BEATS - 1);
    e_wr   = acc;
    e_done = last;
    e_rden = pid && !pf && ((m_cnt + int'(addr)) < MAXO);
    if (valid && m_cnt == 0) m_unexp = 1;
`ifdef RD_TIMEOUT_EN
    if (m_cnt == 0 || valid) m_wd = 0;
    else if (m_wd < TIMEOUT) begin
      m_wd++;
      if (m_wd == TIMEOUT) m_tmo = 1;
    end
`endif
    if (addr && !last) begin
      if (m_cnt == MAXO) m_ovf = 1;
      else m_cnt++;
    end else if (last && !addr) m_cnt--;
    if (acc) m_beat = last ? 0 : m_beat + 1;
    @(posedge sys_clk); #1;
    chk("wr_en", out_fifo_wr_en, e_wr);
    if (e_wr) chk("din", out_fifo_din, data);
    chk("burst_done", burst_done, e_done);
    chk("cnt", outstanding_cnt, m_cnt);
    chk("rd_en", rd_en, e_rden);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_unexpected", err_unexpected, m_unexp);
    chk("err_timeout", err_timeout, m_tmo);
    if (out_fifo_wr_en) begin wr_count++; got_q.push_back(out_fifo_din); end
    if (burst_done) done_count++;
  endtask

  typedef struct {
    bit          addr;
    bit          valid;
    logic [DW-1:0] data;
    int          e_cnt;
    bit          e_wr;
    logic [DW-1:0] e_din;
    bit          e_done;
    bit          e_rden;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // single read: 0 -> 1 -> 0, data returned one cycle late
    vecs[0] = '{1, 0, 64'h0,  1, 0, 64'h0,  0, 1};
    vecs[1] = '{0, 1, 64'hA0, 1, 1, 64'hA0, 0, 1};
    vecs[2] = '{0, 1, 64'hA1, 1, 1, 64'hA1, 0, 1};
    vecs[3] = '{0, 1, 64'hA2, 1, 1, 64'hA2, 0, 1};
    vecs[4] = '{0, 1, 64'hA3, 0, 1, 64'hA3, 1, 1};
    vecs[5] = '{0, 0, 64'h0,  0, 0, 64'h0,  0, 1};

    reset_dut();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].addr, vecs[i].valid, vecs[i].data, 0, 1);
      chk("tbl_cnt", outstanding_cnt, vecs[i].e_cnt);
      chk("tbl_wr", out_fifo_wr_en, vecs[i].e_wr);
      if (vecs[i].e_wr) chk("tbl_din", out_fifo_din, vecs[i].e_din);
      chk("tbl_done", burst_done, vecs[i].e_done);
      chk("tbl_rden", rd_en, vecs[i].e_rden);
    end

    // credit limit and overflow
    reset_dut();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
    chk("credit_rden_low", rd_en, 0);
    chk("credit_cnt8", outstanding_cnt, 8);
    step(1, 0, 0, 0, 1);
    chk("ovf_set", err_overflow, 1);
    chk("ovf_cnt_sat", outstanding_cnt, 8);
    for (int i = 0; i < BEATS; i++) step(0, 1, 64'(i), 0, 1);
    step(0, 0, 0, 0, 1);
    chk("credit_cnt7", outstanding_cnt, 7);
    chk("credit_rden_back", rd_en, 1);

    // command coincident with last beat
    reset_dut();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 64'(i), 0, 1);
    step(1, 1, 64'h3, 0, 1);
    chk("simul_cnt3", outstanding_cnt, 3);
    chk("simul_done", burst_done, 1);

    // gapped burst then back-to-back burst
    reset_dut();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 64'hB0 + 64'(i), 0, 1);
      if (i < 2) begin step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); end
    end
    step(0, 0, 0, 0, 1);
    chk("b2b_writes", wr_count, 8);
    chk("b2b_dones", done_count, 2);
    for (int i = 0; i < 8; i++) begin
      if (got_q.size() > 0) chk("b2b_order", got_q.pop_front(), 64'hB0 + 64'(i));
      else chk("b2b_order_missing", 0, 1);
    end
    chk("b2b_cnt0", outstanding_cnt, 0);

    // unexpected beat and backpressure
    reset_dut();
    step(0, 1, 64'hDEAD, 0, 1);
    chk("unexp_flag", err_unexpected, 1);
    chk("unexp_nowr", out_fifo_wr_en, 0);
    step(0, 0, 0, 0, 1);
    chk("bp_rden_hi", rd_en, 1);
    step(0, 0, 0, 1, 1);
    chk("bp_rden_lo", rd_en, 0);

    // reset in the middle of a burst discards it
    reset_dut();
    step(1, 0, 0, 0, 1);
    step(0, 1, 64'h11, 0, 1);
    step(0, 1, 64'h12, 0, 1);
    rd_data_valid = 1; rd_data_fifo_out = 64'h13;
    reset = 1'b1; #1;
    chk("midrst_wr", out_fifo_wr_en, 0);
    chk("midrst_cnt", outstanding_cnt, 0);
    @(posedge sys_clk); #1;
    chk("midrst_wr_edge", out_fifo_wr_en, 0);
    reset = 1'b0;
    m_cnt = 0; m_beat = 0; m_wd = 0; m_ovf = 0; m_unexp = 0; m_tmo = 0;
    step(0, 1, 64'h14, 0, 1);
    chk("postrst_wr", out_fifo_wr_en, 0);

    // watchdog
    reset_dut();
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 1);
`ifdef RD_TIMEOUT_EN
    chk("wd_timeout", err_timeout, 1);
`else
    chk("wd_timeout_off", err_timeout, 0);
`endif

    // randomized traffic
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      bit a, v, p, d;
      a = ($urandom % 4) == 0;
      v = (m_cnt > 0) ? (($urandom % 3) != 0) : (($urandom % 40) == 0);
      p = ($urandom % 8) == 0;
      d = ($urandom % 32) != 0;
      step(a, v, {$urandom, $urandom}, p, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
